zapper_port: RTL and testbench

ZAPPER_PORT -- requirements
Module: zapper_port

---
 rtl/zapper_pkg.sv | 48 ++++
 rtl/joypad_shift.sv | 52 +++++
 rtl/zapper_port.sv | 95 +++++++++
 tb/tb_zapper_port.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zapper_pkg.sv
// Shared constants for the NES controller port block: button bit order,
// positions of the bits returned to the CPU, and the shift fill default.
package zapper_pkg;

  // Width of a pad shift register and of the CPU-visible data nibble+1
  localparam int PAD_W  = 8;
  localparam int DOUT_W = 5;

  // Button bit indices within a pad byte (1 = pressed)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Bit positions inside the D4..D0 value returned on a port read
  localparam int DOUT_D0    = 0;
  localparam int DOUT_LIGHT = 3;
  localparam int DOUT_TRIG  = 4;

  // Value a standard pad shifts in once its eight buttons are exhausted
  localparam logic DEFAULT_SHIFT_FILL = 1'b1;

  // Idle level of the zapper light line (active-low, so 1 = no light)
  localparam logic LIGHT_IDLE = 1'b1;
  localparam logic TRIG_IDLE  = 1'b0;

  // Build the value a standard pad presents on a read
  function automatic logic [DOUT_W-1:0] pad_dout(input logic d0);
    logic [DOUT_W-1:0] r;
    r = '0;
    r[DOUT_D0] = d0;
    return r;
  endfunction

  // Build the value the zapper presents on a port 2 read
  function automatic logic [DOUT_W-1:0] zapper_dout(input logic trig, input logic light);
    logic [DOUT_W-1:0] r;
    r = '0;
    r[DOUT_TRIG]  = trig;
    r[DOUT_LIGHT] = light;
    return r;
  endfunction

endpackage

// File: rtl/joypad_shift.sv
// One controller port: an 8-bit parallel-load shift register that reloads
// from the live buttons while strobe is high and otherwise shifts once per
// completed CPU read (detected on the falling edge of the read strobe).
module joypad_shift
  import zapper_pkg::*;
#(
  parameter logic SHIFT_FILL = DEFAULT_SHIFT_FILL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic             rd,
  input  logic [PAD_W-1:0] pad_btn,
  output logic             d0
);

  logic [PAD_W-1:0] sr;
  logic             rd_q;
  logic             armed;
  logic             rd_fall;

  // A read only counts once it has been seen low after reset; this keeps a
  // read that straddled a reset from producing a shift when it ends.
  assign rd_fall = rd_q & ~rd & armed;

  // Track the previous read level and whether the port is armed for edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      rd_q <= rd;
      if (!rd) begin
        armed <= 1'b1;
      end
    end
  end

  // Reload continuously under strobe, otherwise shift right on each read end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (strobe) begin
      sr <= pad_btn;
    end else if (rd_fall) begin
      sr <= {SHIFT_FILL, sr[PAD_W-1:1]};
    end
  end

  assign d0 = sr[0];

endmodule

// File: rtl/zapper_port.sv
// NES $4016/$4017 controller interface: strobe latch, two pad shift
// registers, and an optional zapper on port 2 whose asynchronous light and
// trigger lines pass through a SYNC_STAGES-deep synchronizer.
// SYNC_STAGES must lie in 2..3.
module zapper_port
  import zapper_pkg::*;
#(
  parameter logic SHIFT_FILL  = DEFAULT_SHIFT_FILL,
  parameter int   SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_4016,
  input  logic              wr_data,
  input  logic              rd_4016,
  input  logic              rd_4017,
  input  logic [PAD_W-1:0]  pad1_btn,
  input  logic [PAD_W-1:0]  pad2_btn,
  input  logic              zapper_en,
  input  logic              zapper_light,
  input  logic              zapper_trigger,
  output logic [DOUT_W-1:0] dout_4016,
  output logic [DOUT_W-1:0] dout_4017,
  output logic              strobe
);

  logic                   pad1_d0;
  logic                   pad2_d0;
  logic [SYNC_STAGES-1:0] light_sync;
  logic [SYNC_STAGES-1:0] trig_sync;
  logic                   light_s;
  logic                   trig_s;

  // Latch the strobe level from bit 0 of every CPU write to $4016
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe <= 1'b0;
    end else if (wr_4016) begin
      strobe <= wr_data;
    end
  end

  joypad_shift #(
    .SHIFT_FILL (SHIFT_FILL)
  ) u_port1 (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (strobe),
    .rd      (rd_4016),
    .pad_btn (pad1_btn),
    .d0      (pad1_d0)
  );

  // Port 2 keeps shifting even while the zapper owns the data lines, so
  // switching back to the pad shows wherever the register got to.
  joypad_shift #(
    .SHIFT_FILL (SHIFT_FILL)
  ) u_port2 (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (strobe),
    .rd      (rd_4017),
    .pad_btn (pad2_btn),
    .d0      (pad2_d0)
  );

  // Bring the asynchronous zapper lines into the clock domain; stages reset
  // to the idle levels so the CPU sees "no light, no trigger" after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      light_sync <= {SYNC_STAGES{LIGHT_IDLE}};
      trig_sync  <= {SYNC_STAGES{TRIG_IDLE}};
    end else begin
      light_sync <= {light_sync[SYNC_STAGES-2:0], zapper_light};
      trig_sync  <= {trig_sync[SYNC_STAGES-2:0], zapper_trigger};
    end
  end

  assign light_s = light_sync[SYNC_STAGES-1];
  assign trig_s  = trig_sync[SYNC_STAGES-1];

  // Port 1 always presents pad 1's current bit
  assign dout_4016 = pad_dout(pad1_d0);

  // Port 2 source follows zapper_en directly, without touching any state
  always_comb begin
    dout_4017 = '0;
    if (zapper_en) begin
      dout_4017 = zapper_dout(trig_s, light_s);
    end else begin
      dout_4017 = pad_dout(pad2_d0);
    end
  end

endmodule

// File: tb/tb_zapper_port.sv
// Self-checking bench for zapper_port: a behavioural model (latched byte plus
// shift count per port, sample history for the zapper lines) is compared on
// every falling clock edge, with directed literal checks alongside.
module tb_zapper_port;
  import zapper_pkg::*;

  localparam logic FILL = 1'b1;
  localparam int   S    = 2;

  logic       clk;
  logic       reset_n;
  logic       wr_4016;
  logic       wr_data;
  logic       rd_4016;
  logic       rd_4017;
  logic [7:0] pad1_btn;
  logic [7:0] pad2_btn;
  logic       zapper_en;
  logic       zapper_light;
  logic       zapper_trigger;
  logic [4:0] dout_4016;
  logic [4:0] dout_4017;
  logic       strobe;

  int n_compared;
  int n_mismatched;
  bit cmp_en;

  zapper_port #(
    .SHIFT_FILL  (FILL),
    .SYNC_STAGES (S)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_4016        (wr_4016),
    .wr_data        (wr_data),
    .rd_4016        (rd_4016),
    .rd_4017        (rd_4017),
    .pad1_btn       (pad1_btn),
    .pad2_btn       (pad2_btn),
    .zapper_en      (zapper_en),
    .zapper_light   (zapper_light),
    .zapper_trigger (zapper_trigger),
    .dout_4016      (dout_4016),
    .dout_4017      (dout_4017),
    .strobe         (strobe)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: each port is a latched byte and a count of bits consumed
  logic       m_strobe;
  logic [7:0] m_l1, m_l2;
  int         m_n1, m_n2;
  logic       m_prev1, m_prev2;
  logic       m_open1, m_open2;
  logic       m_hl[8];
  logic       m_ht[8];
  int         m_k;
  logic [4:0] exp16, exp17;

  function automatic logic model_d0(input logic [7:0] l, input int n);
    logic [31:0] idx;
    idx = n;
    return (n < 8) ? l[idx[2:0]] : FILL;
  endfunction

  // A read counts when the CPU raises then drops rd after reset; the bit it
  // consumes is the next one of the latched byte, then the fill value.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_strobe <= 1'b0;
      m_l1 <= 8'h00; m_l2 <= 8'h00;
      m_n1 <= 0;     m_n2 <= 0;
      m_prev1 <= 1'b1; m_prev2 <= 1'b1;
      m_open1 <= 1'b0; m_open2 <= 1'b0;
      m_k <= 0;
    end else begin
      if (wr_4016) m_strobe <= wr_data;
      m_prev1 <= rd_4016;
      m_prev2 <= rd_4017;
      if (rd_4016 && !m_prev1) m_open1 <= 1'b1;
      else if (!rd_4016 && m_open1) m_open1 <= 1'b0;
      if (rd_4017 && !m_prev2) m_open2 <= 1'b1;
      else if (!rd_4017 && m_open2) m_open2 <= 1'b0;
      if (m_strobe) begin
        m_l1 <= pad1_btn; m_n1 <= 0;
        m_l2 <= pad2_btn; m_n2 <= 0;
      end else begin
        if (!rd_4016 && m_open1 && m_n1 < 8) m_n1 <= m_n1 + 1;
        if (!rd_4017 && m_open2 && m_n2 < 8) m_n2 <= m_n2 + 1;
      end
      m_hl[m_k % 8] <= zapper_light;
      m_ht[m_k % 8] <= zapper_trigger;
      m_k <= m_k + 1;
    end
  end

  // Expected outputs derived from the model state
  always_comb begin
    logic lt, tr;
    exp16 = 5'h00;
    exp17 = 5'h00;
    lt = 1'b1;
    tr = 1'b0;
    if (m_k >= S) begin
      lt = m_hl[(m_k - S) % 8];
      tr = m_ht[(m_k - S) % 8];
    end
    exp16[0] = model_d0(m_l1, m_n1);
    if (zapper_en) begin
      exp17[4] = tr;
      exp17[3] = lt;
    end else begin
      exp17[0] = model_d0(m_l2, m_n2);
    end
  end

  task automatic check_output(input string name, input logic [4:0] actual, input logic [4:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_strobe", {4'b0, strobe}, {4'b0, m_strobe});
      check_output("model_dout_4016", dout_4016, exp16);
      check_output("model_dout_4017", dout_4017, exp17);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_4016(input logic v);
    wr_4016 = 1'b1;
    wr_data = v;
    tick();
    wr_4016 = 1'b0;
    wr_data = 1'b0;
  endtask

  // One CPU read on either or both ports, held for 'hold' clock edges
  task automatic apply_read(input bit p1, input bit p2, input int hold,
                            output logic [4:0] v1, output logic [4:0] v2);
    rd_4016 = p1;
    rd_4017 = p2;
    @(negedge clk);
    v1 = dout_4016;
    v2 = dout_4017;
    repeat (hold) tick();
    rd_4016 = 1'b0;
    rd_4017 = 1'b0;
    tick();
  endtask

  logic [4:0] v1, v2;
  logic [9:0] seq81;
  logic [7:0] all_btn;

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    cmp_en = 1'b0;
    reset_n = 1'b0;
    wr_4016 = 1'b0; wr_data = 1'b0;
    rd_4016 = 1'b0; rd_4017 = 1'b0;
    pad1_btn = 8'h00; pad2_btn = 8'h00;
    zapper_en = 1'b0; zapper_light = 1'b1; zapper_trigger = 1'b0;

    // Reset values
    repeat (2) tick();
    check_output("rst_strobe", {4'b0, strobe}, 5'h00);
    check_output("rst_dout_4016", dout_4016, 5'h00);
    check_output("rst_dout_4017", dout_4017, 5'h00);
    zapper_en = 1'b1;
    #1;
    check_output("rst_dout_4017_zap", dout_4017, 5'h08);
    zapper_en = 1'b0;
    #1;
    reset_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Zapper synchronizer latency and trigger/light encoding
    zapper_en = 1'b1;
    repeat (3) tick();
    check_output("zap_idle", dout_4017, 5'h08);
    zapper_light = 1'b0;
    tick();
    check_output("zap_light_t1", {4'b0, dout_4017[3]}, 5'h01);
    tick();
    check_output("zap_light_t2", {4'b0, dout_4017[3]}, 5'h00);
    zapper_light = 1'b1;
    zapper_trigger = 1'b1;
    repeat (2) tick();
    check_output("zap_trigger", dout_4017, 5'h18);
    zapper_en = 1'b0;
    #1;
    check_output("zap_switch_back", dout_4017, 5'h00);
    zapper_trigger = 1'b0;
    repeat (3) tick();

    // Eight buttons then fill: A and Right pressed
    pad1_btn = 8'((1 << BTN_A) | (1 << BTN_RIGHT));
    write_4016(1'b1);
    write_4016(1'b0);
    seq81 = 10'b11_1000_0001;
    for (int i = 0; i < 10; i++) begin
      apply_read(1'b1, 1'b0, 1, v1, v2);
      check_output($sformatf("seq81_read%0d", i), v1, {4'b0, seq81[i]});
    end

    // Long read produces exactly one shift
    pad1_btn = 8'(1 << BTN_B);
    write_4016(1'b1);
    write_4016(1'b0);
    apply_read(1'b1, 1'b0, 5, v1, v2);
    check_output("long_read_bit0", v1, 5'h00);
    apply_read(1'b1, 1'b0, 1, v1, v2);
    check_output("long_read_bit1", v1, 5'h01);
    apply_read(1'b1, 1'b0, 1, v1, v2);
    check_output("long_read_bit2", v1, 5'h00);

    // Reads under strobe keep returning live A
    pad1_btn = 8'h00;
    write_4016(1'b1);
    tick();
    check_output("strobe_live_a0", dout_4016, 5'h00);
    pad1_btn = 8'(1 << BTN_A);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      apply_read(1'b1, 1'b0, 1, v1, v2);
      check_output($sformatf("strobe_read%0d", i), v1, 5'h01);
    end
    write_4016(1'b0);
    apply_read(1'b1, 1'b0, 1, v1, v2);
    check_output("strobe_off_bit0", v1, 5'h01);
    apply_read(1'b1, 1'b0, 1, v1, v2);
    check_output("strobe_off_bit1", v1, 5'h00);

    // Simultaneous falling edges on both ports
    pad1_btn = 8'(1 << BTN_B);
    pad2_btn = 8'(1 << BTN_SELECT);
    write_4016(1'b1);
    write_4016(1'b0);
    apply_read(1'b1, 1'b1, 1, v1, v2);
    check_output("both_p1_bit0", v1, 5'h00);
    check_output("both_p2_bit0", v2, 5'h00);
    apply_read(1'b1, 1'b1, 1, v1, v2);
    check_output("both_p1_bit1", v1, 5'h01);
    check_output("both_p2_bit1", v2, 5'h00);
    apply_read(1'b1, 1'b1, 1, v1, v2);
    check_output("both_p2_bit2", v2, 5'h01);

    // Reset pulse in the middle of a read cancels that read's shift
    all_btn = 8'((1 << BTN_A) | (1 << BTN_B) | (1 << BTN_SELECT) | (1 << BTN_START) |
                 (1 << BTN_UP) | (1 << BTN_DOWN) | (1 << BTN_LEFT) | (1 << BTN_RIGHT));
    pad1_btn = all_btn;
    rd_4016 = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    check_output("midrd_rst_dout", dout_4016, 5'h00);
    check_output("midrd_rst_strobe", {4'b0, strobe}, 5'h00);
    #2;
    reset_n = 1'b1;
    repeat (2) tick();
    rd_4016 = 1'b0;
    repeat (2) tick();
    check_output("midrd_after", dout_4016, 5'h00);
    for (int i = 0; i < 8; i++) begin
      apply_read(1'b1, 1'b0, 1, v1, v2);
      check_output($sformatf("midrd_read%0d", i), v1, 5'h00);
    end
    apply_read(1'b1, 1'b0, 1, v1, v2);
    check_output("midrd_read8_fill", v1, 5'h01);

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
